background_sprite: RTL and testbench



---
 rtl/bg_pkg.sv | 34 +++
 rtl/bg_sun_disc.sv | 25 ++
 rtl/background_sprite.sv | 60 ++++++
 tb/tb_background_sprite.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared types, colour constants and geometry for the procedural VGA background.
package bg_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [9:0] H_ACTIVE  = 10'd640;
    localparam logic [9:0] V_ACTIVE  = 10'd480;
    localparam logic [9:0] GROUND_Y  = 10'd400;
    localparam int         TILE_LOG2 = 4;

    localparam logic [7:0] SKY_R       = 8'd0;
    localparam rgb_t       GRASS_LIGHT = '{r: 8'd34,  g: 8'd139, b: 8'd34};
    localparam rgb_t       GRASS_DARK  = '{r: 8'd0,   g: 8'd100, b: 8'd0};
    localparam rgb_t       HORIZON     = '{r: 8'd255, g: 8'd255, b: 8'd255};
    localparam rgb_t       SUN_COLOR   = '{r: 8'd255, g: 8'd220, b: 8'd0};

    localparam logic [10:0] SUN_X  = 11'd560;
    localparam logic [10:0] SUN_Y  = 11'd80;
    localparam logic [21:0] SUN_R2 = 22'd1024;

    // Bit 0 of the tile-index sum selects light or dark grass.
    function automatic logic checker_parity(input logic [9:0] px, input logic [9:0] py);
        logic [9:0] tx;
        logic [9:0] ty;
        tx = px >> TILE_LOG2;
        ty = (py - GROUND_Y) >> TILE_LOG2;
        return 1'(tx + ty);
    endfunction

endpackage

// File: rtl/bg_sun_disc.sv
// Combinational point-in-disc test for the sun drawn in the sky (used under BG_SUN_EN).
module bg_sun_disc
    import bg_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       in_sun
);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] dx_w;
    logic signed [21:0] dy_w;
    logic        [21:0] dist2;

    assign dx   = $signed({1'b0, x} - SUN_X);
    assign dy   = $signed({1'b0, y} - SUN_Y);
    assign dx_w = 22'(dx);
    assign dy_w = 22'(dy);

    // Squares are non-negative and small enough that the 22-bit sum never wraps.
    assign dist2  = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);
    assign in_sun = (dist2 < SUN_R2);

endmodule

// File: rtl/background_sprite.sv
// Procedural background layer: sky gradient, horizon row, checkered ground, registered RGB.
// Optional sun disc in the sky when BG_SUN_EN is defined.
module background_sprite
    import bg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);

    rgb_t color_d;
    rgb_t color_q;
    logic in_sun;

`ifdef BG_SUN_EN
    bg_sun_disc u_sun (
        .x      (x),
        .y      (y),
        .in_sun (in_sun)
    );
`else
    assign in_sun = 1'b0;
`endif

    always_comb begin
        color_d = '0;
        if (x >= H_ACTIVE || y >= V_ACTIVE) begin
            color_d = '0;
        end else if (y < GROUND_Y) begin
            // y < 400 keeps y>>1 below 200, so y[8:1] is the full 8-bit term.
            color_d.r = SKY_R;
            color_d.g = y[9:2];
            color_d.b = 8'd255 - y[8:1];
            if (in_sun) begin
                color_d = SUN_COLOR;
            end
        end else if (y == GROUND_Y) begin
            color_d = HORIZON;
        end else begin
            color_d = checker_parity(x, y) ? GRASS_DARK : GRASS_LIGHT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color_q <= '0;
        end else begin
            color_q <= color_d;
        end
    end

    assign R = color_q.r;
    assign G = color_q.g;
    assign B = color_q.b;

endmodule

// File: tb/tb_background_sprite.sv
// Bench for background_sprite: directed table, raster sweep with mid-line reset, random coordinates.
// Follows BG_SUN_EN the same way as the design.
module tb_background_sprite;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          px;
        int          py;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    background_sprite dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y),
        .R     (R),
        .G     (G),
        .B     (B)
    );

    always #5 clk = ~clk;

    // Reference colour straight from the drawing rules, using plain integer arithmetic.
    function automatic logic [23:0] ref_color(int px, int py);
        int gy;
        if (px >= 640 || py >= 480) return 24'h000000;
        if (py < 400) begin
`ifdef BG_SUN_EN
            if ((px - 560) * (px - 560) + (py - 80) * (py - 80) < 1024) return {8'd255, 8'd220, 8'd0};
`endif
            return {8'd0, 8'(py / 4), 8'(255 - py / 2)};
        end
        if (py == 400) return 24'hFFFFFF;
        gy = py - 400;
        if (((px / 16) + (gy / 16)) % 2 == 0) return {8'd34, 8'd139, 8'd34};
        return {8'd0, 8'd100, 8'd0};
    endfunction

    task automatic check(input string name, input logic [23:0] exp);
        checks++;
        if ({R, G, B} !== exp) begin
            errors++;
            $display("FAIL %s: got rgb=%h expected rgb=%h (x=%0d y=%0d)", name, {R, G, B}, exp, x, y);
        end
    endtask

    task automatic drive(input int px, input int py);
        x = px[9:0];
        y = py[9:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rows[$];
        int px;
        int py;

        reset = 1'b1;
        x = 10'd100;
        y = 10'd100;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_sky", {8'd0, 8'd25, 8'd205});

        // Assert reset between edges: outputs must clear without a clock edge.
        #3;
        reset = 1'b0;
        #1;
        check("reset_async", 24'h000000);
        drive(100, 100);
        check("reset_held", 24'h000000);
        #2;
        reset = 1'b1;
        drive(0, 0);
        check("first_after_release", {8'd0, 8'd0, 8'd255});

        tbl.push_back('{100, 100, {8'd0, 8'd25, 8'd205}});
        tbl.push_back('{5,   399, {8'd0, 8'd99, 8'd56}});
        tbl.push_back('{0,   400, 24'hFFFFFF});
        tbl.push_back('{639, 400, 24'hFFFFFF});
        tbl.push_back('{0,   401, {8'd34, 8'd139, 8'd34}});
        tbl.push_back('{16,  401, {8'd0, 8'd100, 8'd0}});
        tbl.push_back('{16,  417, {8'd34, 8'd139, 8'd34}});
        tbl.push_back('{640, 10,  24'h000000});
        tbl.push_back('{5,   480, 24'h000000});
        tbl.push_back('{639, 479, {8'd0, 8'd100, 8'd0}});
        tbl.push_back('{1023, 1023, 24'h000000});
`ifdef BG_SUN_EN
        tbl.push_back('{560, 80, {8'd255, 8'd220, 8'd0}});
        tbl.push_back('{591, 80, {8'd255, 8'd220, 8'd0}});
`else
        tbl.push_back('{560, 80, {8'd0, 8'd20, 8'd215}});
`endif
        tbl.push_back('{592, 80, {8'd0, 8'd20, 8'd215}});
        foreach (tbl[i]) begin
            drive(tbl[i].px, tbl[i].py);
            check($sformatf("table_%0d", i), tbl[i].exp);
        end

        rows = '{0, 1, 2, 48, 64, 72, 79, 80, 88, 96, 104, 111, 112, 200, 398, 399,
                 400, 401, 415, 416, 417, 432, 478, 479, 480, 481};
        foreach (rows[r]) begin
            for (int cx = 0; cx < 650; cx++) begin
                drive(cx, rows[r]);
                check("sweep", ref_color(cx, rows[r]));
                if (r == 5 && cx == 300) begin
                    reset = 1'b0;
                    #1;
                    check("sweep_rst_async", 24'h000000);
                    for (int k = 0; k < 3; k++) begin
                        drive(cx, rows[r]);
                        check("sweep_rst_held", 24'h000000);
                    end
                    #2;
                    reset = 1'b1;
                end
            end
        end

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                px = $urandom_range(520, 600);
                py = $urandom_range(40, 120);
            end else begin
                px = $urandom_range(0, 700);
                py = $urandom_range(0, 520);
            end
            drive(px, py);
            check("random", ref_color(px, py));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
